// File: rtl/freelist_ckpt_if.sv
// Rename-side bundle for freelist_ckpt: tag grants, commit releases, checkpoint take/free and recovery.
// master = rename/ROB/branch side driving requests, slave = the free list.
interface freelist_ckpt_if #(
   parameter int PHY_REG_NUM = 64,
   parameter int ALLOC_W     = 2,
   parameter int REL_W       = 2,
   parameter int CKPT_NUM    = 4
);
   localparam int PHY_REG_SEL = $clog2(PHY_REG_NUM);
   localparam int CKPT_SEL    = $clog2(CKPT_NUM);

   logic [ALLOC_W-1:0]             req_valid;
   logic                           stall;
   logic [ALLOC_W*PHY_REG_SEL-1:0] alloc_tag;
   logic [ALLOC_W-1:0]             alloc_valid;
   logic                           allocatable;
   logic [REL_W-1:0]               rel_valid;
   logic [REL_W*PHY_REG_SEL-1:0]   rel_tag;
   logic                           ckpt_req;
   logic [CKPT_SEL-1:0]            ckpt_tag;
   logic                           ckpt_full;
   logic                           ckpt_free;
   logic [CKPT_SEL-1:0]            ckpt_free_tag;
   logic                           prmiss;
   logic [CKPT_SEL-1:0]            prmiss_tag;
   logic [PHY_REG_SEL:0]           freenum;

   modport master (
      output req_valid, stall, rel_valid, rel_tag, ckpt_req,
             ckpt_free, ckpt_free_tag, prmiss, prmiss_tag,
      input  alloc_tag, alloc_valid, allocatable, ckpt_tag, ckpt_full, freenum
   );

   modport slave (
      input  req_valid, stall, rel_valid, rel_tag, ckpt_req,
             ckpt_free, ckpt_free_tag, prmiss, prmiss_tag,
      output alloc_tag, alloc_valid, allocatable, ckpt_tag, ckpt_full, freenum
   );
endinterface

// File: rtl/freelist_ckpt.sv
// Physical-tag free list with branch checkpoints; grants are combinational (0-cycle), state updates next edge.
// Backpressure: stall or !allocatable blocks all grants; ckpt_full drops ckpt_req, upstream must hold.
module freelist_ckpt #(
   parameter int PHY_REG_NUM = 64,
   parameter int PHY_REG_SEL = $clog2(PHY_REG_NUM),
   parameter int ALLOC_W     = 2,
   parameter int REL_W       = 2,
   parameter int CKPT_NUM    = 4,
   parameter int CKPT_SEL    = $clog2(CKPT_NUM)
) (
   input  logic           clk,
   input  logic           reset,
   freelist_ckpt_if.slave fl
);
   localparam int               CNT_W    = PHY_REG_SEL + 1;
   localparam logic [CNT_W-1:0] ALL_FREE = CNT_W'(PHY_REG_NUM);

   logic [PHY_REG_NUM-1:0] free_bits, free_bits_nxt;
   logic [CNT_W-1:0]       freenum, freenum_nxt;
   logic [CKPT_NUM-1:0]    ckpt_valid, ckpt_valid_nxt;
   logic [PHY_REG_NUM-1:0] alloc_since [CKPT_NUM];
   logic [CKPT_NUM-1:0]    dep         [CKPT_NUM];
   logic [CKPT_NUM-1:0]    dep_nxt     [CKPT_NUM];

   logic [PHY_REG_NUM-1:0] slot_oh [ALLOC_W];
   logic [PHY_REG_NUM-1:0] avail, grant_mask, fired_mask, rel_mask;
   logic [CNT_W-1:0]       req_cnt, fire_cnt, rel_cnt;
   logic                   allocatable, fire, take, ckpt_full;
   logic [CKPT_SEL-1:0]    next_ckpt;
   logic [CKPT_NUM-1:0]    kill, free_oh;

   function automatic logic [PHY_REG_SEL-1:0] enc(input logic [PHY_REG_NUM-1:0] v);
      enc = '0;
      for (int t = 0; t < PHY_REG_NUM; t++)
         if (v[t]) enc = enc | t[PHY_REG_SEL-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] popcnt(input logic [PHY_REG_NUM-1:0] v);
      popcnt = '0;
      for (int t = 0; t < PHY_REG_NUM; t++)
         popcnt = popcnt + {{(CNT_W-1){1'b0}}, v[t]};
   endfunction

   // Each requesting slot peels the lowest remaining free bit, so tags ascend with slot order.
   always_comb begin
      avail      = free_bits;
      grant_mask = '0;
      req_cnt    = '0;
      for (int s = 0; s < ALLOC_W; s++) begin
         slot_oh[s] = '0;
         if (fl.req_valid[s]) begin
            slot_oh[s] = avail & (~avail + 1'b1);
            avail      = avail & ~slot_oh[s];
            grant_mask = grant_mask | slot_oh[s];
            req_cnt    = req_cnt + 1'b1;
         end
      end
   end

   assign allocatable = (freenum >= req_cnt);
   assign fire        = allocatable & ~fl.stall & ~fl.prmiss;
   assign fired_mask  = fire ? grant_mask : '0;
   assign fire_cnt    = fire ? req_cnt : '0;

   always_comb begin
      fl.alloc_valid = '0;
      fl.alloc_tag   = '0;
      for (int s = 0; s < ALLOC_W; s++) begin
         fl.alloc_valid[s] = fl.req_valid[s] & allocatable;
         if (fl.req_valid[s]) fl.alloc_tag[s*PHY_REG_SEL +: PHY_REG_SEL] = enc(slot_oh[s]);
      end
   end

   always_comb begin
      rel_mask = '0;
      rel_cnt  = '0;
      for (int r = 0; r < REL_W; r++) begin
         if (fl.rel_valid[r]) begin
            rel_mask[fl.rel_tag[r*PHY_REG_SEL +: PHY_REG_SEL]] = 1'b1;
            rel_cnt = rel_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      next_ckpt = '0;
      for (int c = CKPT_NUM - 1; c >= 0; c--)
         if (!ckpt_valid[c]) next_ckpt = c[CKPT_SEL-1:0];
   end

   assign ckpt_full = &ckpt_valid;
   assign take      = fl.ckpt_req & ~ckpt_full & ~fl.prmiss;

   always_comb begin
      free_oh = '0;
      if (fl.ckpt_free) free_oh[fl.ckpt_free_tag] = 1'b1;
      for (int j = 0; j < CKPT_NUM; j++)
         kill[j] = (CKPT_SEL'(j) == fl.prmiss_tag) | dep[j][fl.prmiss_tag];
   end

   // Recovery recounts from the bitmap; the normal path keeps an incremental count.
   always_comb begin
      free_bits_nxt  = (free_bits & ~fired_mask) | rel_mask;
      freenum_nxt    = freenum + rel_cnt - fire_cnt;
      ckpt_valid_nxt = ckpt_valid;
      dep_nxt        = dep;
      if (fl.prmiss) begin
         free_bits_nxt  = free_bits | alloc_since[fl.prmiss_tag] | rel_mask;
         freenum_nxt    = popcnt(free_bits_nxt);
         ckpt_valid_nxt = ckpt_valid & ~kill;
         for (int j = 0; j < CKPT_NUM; j++) dep_nxt[j] = dep[j] & ~kill;
      end else begin
         ckpt_valid_nxt = ckpt_valid & ~free_oh;
         if (take) begin
            ckpt_valid_nxt[next_ckpt] = 1'b1;
            dep_nxt[next_ckpt]        = ckpt_valid;
         end
         for (int j = 0; j < CKPT_NUM; j++) dep_nxt[j] = dep_nxt[j] & ~free_oh;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         free_bits  <= '1;
         freenum    <= ALL_FREE;
         ckpt_valid <= '0;
         for (int c = 0; c < CKPT_NUM; c++) begin
            alloc_since[c] <= '0;
            dep[c]         <= '0;
         end
      end else begin
         free_bits  <= free_bits_nxt;
         freenum    <= freenum_nxt;
         ckpt_valid <= ckpt_valid_nxt;
         for (int c = 0; c < CKPT_NUM; c++) begin
            dep[c] <= dep_nxt[c];
            if (take && next_ckpt == CKPT_SEL'(c))
               alloc_since[c] <= '0;
            else if (ckpt_valid[c])
               alloc_since[c] <= alloc_since[c] | fired_mask;
         end
      end
   end

   assign fl.allocatable = allocatable;
   assign fl.ckpt_tag    = next_ckpt;
   assign fl.ckpt_full   = ckpt_full;
   assign fl.freenum     = freenum;

   for (genvar i = 0; i < REL_W; i++) begin : g_rel_chk
      a_rel_not_free: assert property (@(posedge clk) disable iff (reset)
         fl.rel_valid[i] |-> !free_bits[fl.rel_tag[i*PHY_REG_SEL +: PHY_REG_SEL]])
         else $error("freelist_ckpt: released tag is already free");
      for (genvar j = i + 1; j < REL_W; j++) begin : g_dup
         a_rel_dup: assert property (@(posedge clk) disable iff (reset)
            (fl.rel_valid[i] && fl.rel_valid[j]) |->
            (fl.rel_tag[i*PHY_REG_SEL +: PHY_REG_SEL] != fl.rel_tag[j*PHY_REG_SEL +: PHY_REG_SEL]))
            else $error("freelist_ckpt: duplicate release tag");
      end
   end

   a_prmiss_valid: assert property (@(posedge clk) disable iff (reset)
      fl.prmiss |-> ckpt_valid[fl.prmiss_tag])
      else $error("freelist_ckpt: prmiss names an invalid checkpoint");
   a_free_valid: assert property (@(posedge clk) disable iff (reset)
      fl.ckpt_free |-> ckpt_valid[fl.ckpt_free_tag])
      else $error("freelist_ckpt: ckpt_free names an invalid checkpoint");
   a_free_ne_prmiss: assert property (@(posedge clk) disable iff (reset)
      (fl.ckpt_free && fl.prmiss) |-> (fl.ckpt_free_tag != fl.prmiss_tag))
      else $error("freelist_ckpt: ckpt_free and prmiss name the same checkpoint");
endmodule

// File: tb/tb_freelist_ckpt.sv
// Bench for freelist_ckpt: inputs change on the falling edge, grants are scoreboarded just before the rising edge.
module tb_freelist_ckpt;
   localparam int N = 64, SEL = 6, AW = 2, RW = 2, CN = 4, CS = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [SEL-1:0] exp_q[$];

   always #5 clk = ~clk;

   freelist_ckpt_if #(.PHY_REG_NUM(N), .ALLOC_W(AW), .REL_W(RW), .CKPT_NUM(CN)) fl ();

   freelist_ckpt #(.PHY_REG_NUM(N), .PHY_REG_SEL(SEL), .ALLOC_W(AW), .REL_W(RW),
                   .CKPT_NUM(CN), .CKPT_SEL(CS)) dut (
      .clk   (clk),
      .reset (reset),
      .fl    (fl)
   );

   // Every grant that fires must match the next expected tag.
   initial begin
      logic [SEL-1:0] exp_tag;
      logic [SEL-1:0] got_tag;
      forever begin
         @(negedge clk);
         #4;
         if (!reset && !fl.stall && !fl.prmiss) begin
            for (int s = 0; s < AW; s++) begin
               if (fl.alloc_valid[s]) begin
                  got_tag = fl.alloc_tag[s*SEL +: SEL];
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL grant_unexpected slot=%0d got=%0d expected no grant", s, got_tag);
                  end else begin
                     exp_tag = exp_q.pop_front();
                     if (got_tag !== exp_tag) begin
                        failures++;
                        $display("FAIL grant_tag slot=%0d got=%0d exp=%0d", s, got_tag, exp_tag);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish (checks=%0d failures=%0d)", checks, failures);
      $fatal(1);
   end

   task automatic idle();
      fl.req_valid = '0; fl.stall = 1'b0; fl.rel_valid = '0; fl.rel_tag = '0;
      fl.ckpt_req = 1'b0; fl.ckpt_free = 1'b0; fl.ckpt_free_tag = '0;
      fl.prmiss = 1'b0; fl.prmiss_tag = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      idle();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      fl.req_valid = 2'b11; fl.ckpt_req = 1'b1; fl.rel_valid = 2'b01; fl.rel_tag = 12'd7;
      @(negedge clk);
      @(negedge clk);
      idle();
      reset = 1'b0;
      #1;
      checks++; if (fl.freenum !== 7'd64) begin failures++; $display("FAIL reset_freenum got=%0d exp=64", fl.freenum); end
      checks++; if (fl.ckpt_tag !== 2'd0) begin failures++; $display("FAIL reset_ckpt_tag got=%0d exp=0", fl.ckpt_tag); end
      checks++; if (fl.ckpt_full !== 1'b0) begin failures++; $display("FAIL reset_ckpt_full got=%0b exp=0", fl.ckpt_full); end
      checks++; if (fl.alloc_valid !== 2'b00) begin failures++; $display("FAIL reset_alloc_valid got=%b exp=00", fl.alloc_valid); end
      checks++; if (fl.allocatable !== 1'b1) begin failures++; $display("FAIL reset_allocatable got=%0b exp=1", fl.allocatable); end
      @(negedge clk);
   endtask

   task automatic test_alloc_pair();
      apply_reset();
      fl.req_valid = 2'b11;
      exp_q.push_back(6'd0); exp_q.push_back(6'd1);
      #1;
      checks++; if (fl.alloc_valid !== 2'b11) begin failures++; $display("FAIL pair_valid0 got=%b exp=11", fl.alloc_valid); end
      checks++; if (fl.freenum !== 7'd64) begin failures++; $display("FAIL pair_freenum0 got=%0d exp=64", fl.freenum); end
      @(negedge clk);
      exp_q.push_back(6'd2); exp_q.push_back(6'd3);
      #1;
      checks++; if (fl.alloc_valid !== 2'b11) begin failures++; $display("FAIL pair_valid1 got=%b exp=11", fl.alloc_valid); end
      checks++; if (fl.freenum !== 7'd62) begin failures++; $display("FAIL pair_freenum1 got=%0d exp=62", fl.freenum); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (fl.freenum !== 7'd60) begin failures++; $display("FAIL pair_freenum2 got=%0d exp=60", fl.freenum); end
   endtask

   task automatic test_partial_stall();
      apply_reset();
      fl.req_valid = 2'b10;
      fl.stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (fl.alloc_valid !== 2'b10) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=10", c, fl.alloc_valid); end
         checks++; if (fl.alloc_tag !== 12'd0) begin failures++; $display("FAIL stall_tags cyc=%0d got=%h exp=000", c, fl.alloc_tag); end
         checks++; if (fl.freenum !== 7'd64) begin failures++; $display("FAIL stall_freenum cyc=%0d got=%0d exp=64", c, fl.freenum); end
         @(negedge clk);
      end
      fl.stall = 1'b0;
      exp_q.push_back(6'd0);
      @(negedge clk);
      exp_q.push_back(6'd1);
      #1;
      checks++; if (fl.freenum !== 7'd63) begin failures++; $display("FAIL partial_freenum got=%0d exp=63", fl.freenum); end
      checks++; if (fl.alloc_tag !== {6'd1, 6'd0}) begin failures++; $display("FAIL partial_tags got=%h exp=040", fl.alloc_tag); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (fl.freenum !== 7'd62) begin failures++; $display("FAIL partial_freenum2 got=%0d exp=62", fl.freenum); end
   endtask

   task automatic test_exhaust();
      apply_reset();
      fl.req_valid = 2'b11;
      for (int c = 0; c < 32; c++) begin
         exp_q.push_back(6'(2*c)); exp_q.push_back(6'(2*c + 1));
         @(negedge clk);
      end
      #1;
      checks++; if (fl.allocatable !== 1'b0) begin failures++; $display("FAIL empty_allocatable got=%0b exp=0", fl.allocatable); end
      checks++; if (fl.alloc_valid !== 2'b00) begin failures++; $display("FAIL empty_valid got=%b exp=00", fl.alloc_valid); end
      checks++; if (fl.freenum !== 7'd0) begin failures++; $display("FAIL empty_freenum got=%0d exp=0", fl.freenum); end
      fl.req_valid = 2'b01;
      fl.rel_valid = 2'b01;
      fl.rel_tag   = 12'd5;
      #1;
      checks++; if (fl.allocatable !== 1'b0) begin failures++; $display("FAIL rel_no_bypass got=%0b exp=0", fl.allocatable); end
      @(negedge clk);
      fl.rel_valid = '0;
      fl.req_valid = 2'b11;
      #1;
      checks++; if (fl.allocatable !== 1'b0) begin failures++; $display("FAIL rel_pair_refused got=%0b exp=0", fl.allocatable); end
      fl.req_valid = 2'b01;
      exp_q.push_back(6'd5);
      #1;
      checks++; if (fl.allocatable !== 1'b1) begin failures++; $display("FAIL rel_single_ok got=%0b exp=1", fl.allocatable); end
      checks++; if (fl.alloc_valid !== 2'b01) begin failures++; $display("FAIL rel_single_valid got=%b exp=01", fl.alloc_valid); end
      checks++; if (fl.freenum !== 7'd1) begin failures++; $display("FAIL rel_freenum got=%0d exp=1", fl.freenum); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (fl.freenum !== 7'd0) begin failures++; $display("FAIL rel_refire_freenum got=%0d exp=0", fl.freenum); end
   endtask

   task automatic test_recover();
      apply_reset();
      fl.req_valid = 2'b11; fl.ckpt_req = 1'b1;
      exp_q.push_back(6'd0); exp_q.push_back(6'd1);
      #1;
      checks++; if (fl.ckpt_tag !== 2'd0) begin failures++; $display("FAIL rec_ckpt_a got=%0d exp=0", fl.ckpt_tag); end
      @(negedge clk);
      fl.ckpt_req = 1'b0;
      exp_q.push_back(6'd2); exp_q.push_back(6'd3);
      @(negedge clk);
      fl.req_valid = 2'b00; fl.ckpt_req = 1'b1;
      #1;
      checks++; if (fl.ckpt_tag !== 2'd1) begin failures++; $display("FAIL rec_ckpt_b got=%0d exp=1", fl.ckpt_tag); end
      @(negedge clk);
      fl.ckpt_req = 1'b0; fl.req_valid = 2'b11;
      exp_q.push_back(6'd4); exp_q.push_back(6'd5);
      #1;
      checks++; if (fl.ckpt_tag !== 2'd2) begin failures++; $display("FAIL rec_ckpt_next got=%0d exp=2", fl.ckpt_tag); end
      @(negedge clk);
      fl.req_valid = 2'b00; fl.prmiss = 1'b1; fl.prmiss_tag = 2'd0;
      #1;
      checks++; if (fl.freenum !== 7'd58) begin failures++; $display("FAIL rec_pre_freenum got=%0d exp=58", fl.freenum); end
      @(negedge clk);
      fl.prmiss = 1'b0; fl.req_valid = 2'b11; fl.ckpt_req = 1'b1;
      exp_q.push_back(6'd2); exp_q.push_back(6'd3);
      #1;
      checks++; if (fl.freenum !== 7'd62) begin failures++; $display("FAIL rec_freenum got=%0d exp=62", fl.freenum); end
      checks++; if (fl.ckpt_tag !== 2'd0) begin failures++; $display("FAIL rec_ckpt_tag got=%0d exp=0", fl.ckpt_tag); end
      checks++; if (fl.ckpt_full !== 1'b0) begin failures++; $display("FAIL rec_ckpt_full got=%0b exp=0", fl.ckpt_full); end
      @(negedge clk);
      fl.ckpt_req = 1'b0;
      exp_q.push_back(6'd4); exp_q.push_back(6'd5);
      #1;
      checks++; if (fl.ckpt_tag !== 2'd1) begin failures++; $display("FAIL rec_b_invalid got=%0d exp=1", fl.ckpt_tag); end
      checks++; if (fl.freenum !== 7'd60) begin failures++; $display("FAIL rec_freenum2 got=%0d exp=60", fl.freenum); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (fl.freenum !== 7'd58) begin failures++; $display("FAIL rec_freenum3 got=%0d exp=58", fl.freenum); end
   endtask

   task automatic test_ckpt_full();
      apply_reset();
      fl.ckpt_req = 1'b1; fl.req_valid = 2'b11;
      for (int c = 0; c < CN; c++) begin
         exp_q.push_back(6'(2*c)); exp_q.push_back(6'(2*c + 1));
         #1;
         checks++; if (fl.ckpt_tag !== 2'(c)) begin failures++; $display("FAIL full_ckpt_tag c=%0d got=%0d exp=%0d", c, fl.ckpt_tag, c); end
         checks++; if (fl.ckpt_full !== 1'b0) begin failures++; $display("FAIL full_early c=%0d got=%0b exp=0", c, fl.ckpt_full); end
         @(negedge clk);
      end
      fl.req_valid = 2'b00;
      #1;
      checks++; if (fl.ckpt_full !== 1'b1) begin failures++; $display("FAIL full_set got=%0b exp=1", fl.ckpt_full); end
      @(negedge clk);
      fl.ckpt_req = 1'b0; fl.ckpt_free = 1'b1; fl.ckpt_free_tag = 2'd2;
      #1;
      checks++; if (fl.ckpt_full !== 1'b1) begin failures++; $display("FAIL full_ignored got=%0b exp=1", fl.ckpt_full); end
      @(negedge clk);
      fl.ckpt_free = 1'b0;
      #1;
      checks++; if (fl.ckpt_tag !== 2'd2) begin failures++; $display("FAIL free_ckpt_tag got=%0d exp=2", fl.ckpt_tag); end
      checks++; if (fl.ckpt_full !== 1'b0) begin failures++; $display("FAIL free_ckpt_full got=%0b exp=0", fl.ckpt_full); end
      checks++; if (fl.freenum !== 7'd56) begin failures++; $display("FAIL full_freenum got=%0d exp=56", fl.freenum); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (fl.ckpt_tag !== 2'd0) begin failures++; $display("FAIL midreset_ckpt_tag got=%0d exp=0", fl.ckpt_tag); end
      checks++; if (fl.freenum !== 7'd64) begin failures++; $display("FAIL midreset_freenum got=%0d exp=64", fl.freenum); end
   endtask

   task automatic test_prmiss_same_cycle();
      apply_reset();
      fl.req_valid = 2'b11;
      exp_q.push_back(6'd0); exp_q.push_back(6'd1);
      @(negedge clk);
      exp_q.push_back(6'd2); exp_q.push_back(6'd3);
      @(negedge clk);
      fl.req_valid = 2'b00; fl.ckpt_req = 1'b1;
      @(negedge clk);
      fl.ckpt_req = 1'b0; fl.req_valid = 2'b11;
      for (int c = 0; c < 4; c++) begin
         exp_q.push_back(6'(4 + 2*c)); exp_q.push_back(6'(5 + 2*c));
         @(negedge clk);
      end
      fl.prmiss = 1'b1; fl.prmiss_tag = 2'd0;
      fl.rel_valid = 2'b01; fl.rel_tag = 12'd2;
      fl.ckpt_req = 1'b1;
      #1;
      checks++; if (fl.freenum !== 7'd52) begin failures++; $display("FAIL pm_pre_freenum got=%0d exp=52", fl.freenum); end
      @(negedge clk);
      idle();
      fl.ckpt_req = 1'b1;
      #1;
      checks++; if (fl.freenum !== 7'd61) begin failures++; $display("FAIL pm_freenum got=%0d exp=61", fl.freenum); end
      checks++; if (fl.ckpt_tag !== 2'd0) begin failures++; $display("FAIL pm_ckpt_tag got=%0d exp=0", fl.ckpt_tag); end
      @(negedge clk);
      fl.ckpt_req = 1'b0; fl.req_valid = 2'b11;
      exp_q.push_back(6'd2); exp_q.push_back(6'd4);
      #1;
      checks++; if (fl.ckpt_tag !== 2'd1) begin failures++; $display("FAIL pm_no_take got=%0d exp=1", fl.ckpt_tag); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (fl.freenum !== 7'd59) begin failures++; $display("FAIL pm_freenum2 got=%0d exp=59", fl.freenum); end
   endtask

   initial begin
      idle();
      test_reset();
      test_alloc_pair();
      test_partial_stall();
      test_exhaust();
      test_recover();
      test_ckpt_full();
      test_prmiss_same_cycle();
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/freelist_ckpt.md
# freelist_ckpt

Parametrised physical-register free list with branch checkpoints for the rename stage. Each cycle it grants up to ALLOC_W free physical tags, accepts up to REL_W released tags from commit, and records per-checkpoint allocation history. On a branch misprediction it returns every tag allocated after the mispredicted branch's checkpoint to the free pool in one cycle. It sits between decode/rename and dispatch, and is fed by the ROB commit port and the branch unit.

## Interface
- PHY_REG_NUM, 64, number of physical registers; power of two, at least 4
- PHY_REG_SEL, $clog2(PHY_REG_NUM), tag width
- ALLOC_W, 2, allocation slots per cycle, 1..4
- REL_W, 2, release slots per cycle, 1..4
- CKPT_NUM, 4, checkpoint slots, 2..8
- CKPT_SEL, $clog2(CKPT_NUM), checkpoint tag width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  ALLOC_W  slot i requests a destination tag
- stall  in  1  back-end stall; no allocation fires
- alloc_tag  out  ALLOC_W*PHY_REG_SEL  granted tag per slot; slot i occupies bits [i*PHY_REG_SEL +: PHY_REG_SEL]
- alloc_valid  out  ALLOC_W  grant valid per slot
- allocatable  out  1  freenum >= popcount(req_valid)
- rel_valid  in  REL_W  release valid
- rel_tag  in  REL_W*PHY_REG_SEL  released tags
- ckpt_req  in  1  take a checkpoint this cycle
- ckpt_tag  out  CKPT_SEL  slot the next checkpoint will use (lowest free slot)
- ckpt_full  out  1  no free checkpoint slot
- ckpt_free  in  1  branch resolved correctly; release the checkpoint
- ckpt_free_tag  in  CKPT_SEL  checkpoint to release
- prmiss  in  1  misprediction; recover to the checkpoint
- prmiss_tag  in  CKPT_SEL  checkpoint to recover to
- freenum  out  PHY_REG_SEL+1  current count of free tags

## Operation
- State:
  - free_bits[PHY_REG_NUM]
  - freenum
  - ckpt_valid[CKPT_NUM]
  - alloc_since[CKPT_NUM][PHY_REG_NUM]
  - dep[CKPT_NUM][CKPT_NUM]; dep[j][k]=1 means j was taken after k
- Grant logic is combinational from free_bits.
  - Requesting slots, in ascending slot order, receive the lowest-index free tags in ascending order.
  - Non-requesting slots: alloc_valid=0, alloc_tag=0.
  - If !allocatable, all alloc_valid=0.
- fire = allocatable & ~stall & ~prmiss. On fire, granted tags are cleared from free_bits.
  - While stall is high, alloc_tag may change (for example after a release); consumers use it only on fire.
- Releases: rel_valid tags are set in free_bits each cycle unless reset is asserted. Releases are applied even during prmiss.
- freenum_next = freenum + popcount(rel_valid) - popcount(fired grants). On recovery, freenum_next = popcount(free_bits_next).
- Checkpoint take (ckpt_req & ~ckpt_full & ~prmiss):
  - The slot is ckpt_tag. Set its ckpt_valid.
  - Clear its alloc_since; the same-cycle grants are older than the branch.
  - dep[new][k] = ckpt_valid[k] for every k.
- Every valid checkpoint other than a newly taken one ORs the fired grants into its alloc_since.
- ckpt_free (no prmiss): clear ckpt_valid[ckpt_free_tag] and column dep[*][ckpt_free_tag].
- Recovery (prmiss; prmiss_tag must be valid):
  - free_bits_next = free_bits | alloc_since[prmiss_tag] | released tags.
  - Invalidate prmiss_tag and every j with dep[j][prmiss_tag].
  - No grant fires and no checkpoint is taken that cycle.
  - A ckpt_free in the same cycle is ignored.
- ckpt_full=1 with ckpt_req high: the request is ignored. The upstream stage must stall on ckpt_full.
- Illegal inputs, flagged by simulation assertions only:
  - releasing a tag that is already free
  - two release slots carrying the same tag
  - prmiss or ckpt_free naming an invalid checkpoint
  - ckpt_free naming the same tag as prmiss
- Reset:
  - free_bits all ones; freenum = PHY_REG_NUM
  - ckpt_valid = 0; alloc_since = 0; dep = 0
  - outputs: alloc_valid=0 while req_valid=0; ckpt_tag=0; ckpt_full=0
  - reset overrides all other inputs

## Timing
- allocatable, alloc_tag, alloc_valid, ckpt_tag and ckpt_full are combinational from current state and req_valid. Grant latency is 0 cycles.
- A fired tag is never granted in the following cycle unless it has been released or recovered.
- A tag released in cycle N is grantable from cycle N+1; there is no same-cycle bypass.
- Tags recovered in cycle N are grantable from cycle N+1. A ckpt_tag freed in cycle N is offered from cycle N+1.
- Reset asserted mid-operation discards all checkpoints and allocation history in the same edge.

## Test plan
- Reset, then req_valid=2'b11 without stall: grants tags 0 and 1; next cycle 2 and 3; freenum 64→62→60.
- req_valid=2'b10: slot1 gets tag 0, slot0 alloc_valid=0. Stall for 3 cycles: free_bits unchanged, freenum stays 64.
- Allocate all 64 tags: allocatable=0 for req=2'b11. Release tag 5 (rel_valid=1): next cycle req=2'b01 grants 5 and req=2'b11 is still refused.
- Checkpoint A taken with grants 0,1; then grants 2,3; checkpoint B; then grants 4,5; prmiss_tag=A: next cycle free_bits has 2..5 set, B is invalid, freenum=62, and ckpt_tag and ckpt_full show the freed slots.
- Take CKPT_NUM checkpoints: ckpt_full=1 and further ckpt_req is ignored. ckpt_free slot 2: next cycle ckpt_tag=2 and ckpt_full=0.
- Same cycle: prmiss, rel_valid on tag 10, req=2'b11 and ckpt_req. Required: no grants, no checkpoint taken, tag 10 freed, and freenum equals the popcount of the new free_bits.
